// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl : PC sequencer with run/halt control and branch-table redirect
// Rev 1.0
// ============================================================================
module pc_fetch_ctrl #(
    parameter int D  = 12,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_en,
    input  logic          branch_rel,
    input  logic [IW-1:0] branch_idx,
    input  logic [D-1:0]  lut_target,
    output logic [IW-1:0] lut_addr,
    output logic [D-1:0]  pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BRANCH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [D-1:0]  r_pc, w_pc_nxt;
    logic [IW-1:0] r_lut_addr, w_lut_addr_nxt;
    logic          r_rel, w_rel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_lut_addr <= '0;
            r_rel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_lut_addr <= w_lut_addr_nxt;
            r_rel      <= w_rel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_lut_addr_nxt = r_lut_addr;
        w_rel_nxt      = r_rel;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stall) begin
                    w_state_nxt = r_state;
                end else if (halt) begin
                    w_state_nxt = S_DONE;
                end else if (branch_en) begin
                    w_lut_addr_nxt = branch_idx;
                    w_rel_nxt      = branch_rel;
                    w_state_nxt    = S_BRANCH;
                end else begin
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            S_BRANCH: begin
                // r_pc still holds the branch instruction's address here
                if (!stall) begin
                    w_pc_nxt    = r_rel ? (r_pc + lut_target) : lut_target;
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign pc       = r_pc;
    assign lut_addr = r_lut_addr;
    assign busy     = (r_state == S_RUN) || (r_state == S_BRANCH);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// Directed testbench for pc_fetch_ctrl with a small branch-table model.
module tb_pc_fetch_ctrl;

    localparam int D  = 12;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic          halt;
    logic          branch_en;
    logic          branch_rel;
    logic [IW-1:0] branch_idx;
    logic [D-1:0]  lut_target;
    logic [IW-1:0] lut_addr;
    logic [D-1:0]  pc;
    logic          busy;
    logic          done;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.D(D), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .halt       (halt),
        .branch_en  (branch_en),
        .branch_rel (branch_rel),
        .branch_idx (branch_idx),
        .lut_target (lut_target),
        .lut_addr   (lut_addr),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always_comb begin
        case (lut_addr)
            4'd1:    lut_target = 12'd159;
            4'd2:    lut_target = 12'd177;
            4'd3:    lut_target = 12'h333;
            4'd4:    lut_target = 12'hFFB;
            4'd5:    lut_target = 12'h014;
            4'd6:    lut_target = 12'd4;
            4'd7:    lut_target = 12'h010;
            4'd8:    lut_target = 12'd10;
            4'd9:    lut_target = 12'd5;
            default: lut_target = 12'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [D-1:0] epc,
                               input logic [IW-1:0] eaddr, input logic ebusy,
                               input logic edone);
        check({tag, ".pc"},   32'(pc),       32'(epc));
        check({tag, ".addr"}, 32'(lut_addr), 32'(eaddr));
        check({tag, ".busy"}, 32'(busy),     32'(ebusy));
        check({tag, ".done"}, 32'(done),     32'(edone));
    endtask

    task automatic do_branch(input logic [IW-1:0] idx, input logic rel);
        branch_en  = 1'b1;
        branch_idx = idx;
        branch_rel = rel;
        tick();
        branch_en  = 1'b0;
        branch_rel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
        branch_en = 1'b0; branch_rel = 1'b0; branch_idx = '0;
        #12;
        check_state("reset", 12'd0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_state("idle_hold", 12'd0, 4'd0, 1'b0, 1'b0);

        // sequential stepping
        start = 1'b1;
        tick();
        start = 1'b0;
        check_state("start", 12'd0, 4'd0, 1'b1, 1'b0);
        tick(); check("seq1", 32'(pc), 32'd1);
        tick(); check("seq2", 32'(pc), 32'd2);
        tick(); check_state("seq3", 12'd3, 4'd0, 1'b1, 1'b0);
        repeat (4) tick();
        check("seq7", 32'(pc), 32'd7);

        // absolute branch
        do_branch(4'd1, 1'b0);
        check_state("abs_bubble", 12'd7, 4'd1, 1'b1, 1'b0);
        tick(); check("abs_target", 32'(pc), 32'd159);
        tick(); check("abs_next", 32'(pc), 32'd160);

        // relative branch with wrap, then sequential wrap
        do_branch(4'd6, 1'b0);
        tick(); check("to4", 32'(pc), 32'd4);
        do_branch(4'd4, 1'b1);
        check_state("rel_bubble", 12'd4, 4'd4, 1'b1, 1'b0);
        tick(); check("rel_wrap", 32'(pc), 32'hFFF);
        tick(); check("seq_wrap", 32'(pc), 32'h000);
        do_branch(4'd7, 1'b0);
        tick(); check("to10h", 32'(pc), 32'h010);
        do_branch(4'd5, 1'b1);
        tick(); check("rel_fwd", 32'(pc), 32'h024);

        // halt wins over a simultaneous branch
        do_branch(4'd8, 1'b0);
        tick(); check("to10", 32'(pc), 32'd10);
        halt = 1'b1; branch_en = 1'b1; branch_idx = 4'd3;
        tick();
        halt = 1'b0; branch_en = 1'b0;
        check_state("halt", 12'd10, 4'd8, 1'b0, 1'b1);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        check_state("done_hold", 12'd10, 4'd8, 1'b0, 1'b1);
        start = 1'b1; stall = 1'b1;
        tick();
        start = 1'b0; stall = 1'b0;
        check_state("restart", 12'd0, 4'd8, 1'b1, 1'b0);

        // stall in BRANCH and in RUN
        tick(); check("pc1", 32'(pc), 32'd1);
        do_branch(4'd2, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("br_stall", 12'd1, 4'd2, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); check("stall_release", 32'(pc), 32'd177);
        stall = 1'b1; halt = 1'b1;
        tick();
        stall = 1'b0; halt = 1'b0;
        check_state("run_stall", 12'd177, 4'd2, 1'b1, 1'b0);
        tick(); check("after_stall", 32'(pc), 32'd178);

        // asynchronous reset while in BRANCH
        do_branch(4'd9, 1'b0);
        tick(); check("to5", 32'(pc), 32'd5);
        do_branch(4'd1, 1'b0);
        check_state("pre_reset", 12'd5, 4'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_state("async_reset", 12'd0, 4'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        check_state("post_reset", 12'd0, 4'd0, 1'b0, 1'b0);
        tick();
        check_state("post_reset2", 12'd0, 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_state("rerun", 12'd0, 4'd0, 1'b1, 1'b0);
        tick(); check("rerun_step", 32'(pc), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
